// File: rtl/mem_responder.sv
// mem_responder: memory-side responder for the core's fetch, load and store
// method calls. Holds a word-addressed RAM and a single-entry LR/SC
// reservation. Every response is registered and appears exactly one cycle
// after its request strobe.
//
// Ports:
//   CLK, RESET (async active-low)
//   fetch_*  : fetch request (enable, addr) / response (valid, inst, exception)
//   rd_*     : load request (enable, lr, addr) / response (valid, data,
//              reservation status, exception)
//   wr_*     : store request (enable, sc, addr, data) / response (valid,
//              sc_fail, exception)
module mem_responder #(
  parameter int unsigned DEPTH = 1024,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        fetch_enable,
  input  logic [31:0] fetch_addr,
  output logic        fetch_valid,
  output logic [31:0] fetch_inst,
  output logic        fetch_exc_valid,
  output logic [3:0]  fetch_exc_code,
  output logic [31:0] fetch_exc_value,
  input  logic        rd_enable,
  input  logic        rd_lr,
  input  logic [31:0] rd_addr,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic [1:0]  rd_reservation,
  output logic        rd_exc_valid,
  output logic [3:0]  rd_exc_code,
  input  logic        wr_enable,
  input  logic        wr_sc,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_valid,
  output logic        wr_sc_fail,
  output logic        wr_exc_valid,
  output logic [3:0]  wr_exc_code
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef enum logic [0:0] {IDLE = 1'b0, RESERVED = 1'b1} resv_state_e;

  // Offset from BASE with a borrow bit; since BASE is aligned to the RAM
  // span, the low bits are the alignment, the middle bits the word index and
  // any set high bit (or the borrow) means out of range.
  function automatic logic [32:0] offset_of(input logic [31:0] addr);
    return {1'b0, addr} - {1'b0, BASE};
  endfunction

  function automatic logic is_oor(input logic [32:0] off);
    return off[32] | (|off[31:IDX_W+2]);
  endfunction

  logic [31:0]      mem_r [DEPTH];
  resv_state_e      resv_state_r, resv_state_s;
  logic [29:0]      resv_addr_r, resv_addr_s;

  logic [32:0]      f_off_s, r_off_s, w_off_s;
  logic             f_mis_s, f_oor_s, r_mis_s, r_oor_s, w_mis_s, w_oor_s;
  logic             r_match_s, w_match_s, sc_ok_s, mem_we_s;

  logic             fetch_valid_s, fetch_exc_valid_s, rd_valid_s, rd_exc_valid_s;
  logic             wr_valid_s, wr_exc_valid_s, wr_sc_fail_s;
  logic [31:0]      fetch_inst_s, fetch_exc_value_s, rd_data_s;
  logic [3:0]       fetch_exc_code_s, rd_exc_code_s, wr_exc_code_s;
  logic [1:0]       rd_reservation_s;

  assign f_off_s   = offset_of(fetch_addr);
  assign r_off_s   = offset_of(rd_addr);
  assign w_off_s   = offset_of(wr_addr);
  assign f_mis_s   = |f_off_s[1:0];
  assign r_mis_s   = |r_off_s[1:0];
  assign w_mis_s   = |w_off_s[1:0];
  assign f_oor_s   = is_oor(f_off_s);
  assign r_oor_s   = is_oor(r_off_s);
  assign w_oor_s   = is_oor(w_off_s);
  // Reservation matches compare the full word address against the pre-cycle state
  assign r_match_s = (resv_state_r == RESERVED) && (resv_addr_r == rd_addr[31:2]);
  assign w_match_s = (resv_state_r == RESERVED) && (resv_addr_r == wr_addr[31:2]);
  assign sc_ok_s   = wr_sc && w_match_s;
  assign mem_we_s  = wr_enable && !w_mis_s && !w_oor_s && (!wr_sc || sc_ok_s);

  // RAM write port; reads below see the pre-write contents of this cycle
  always_ff @(posedge CLK) begin
    if (mem_we_s) begin
      mem_r[w_off_s[IDX_W+1:2]] <= wr_data;
    end
  end

  // Reservation state register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      resv_state_r <= IDLE;
      resv_addr_r  <= 30'd0;
    end else begin
      resv_state_r <= resv_state_s;
      resv_addr_r  <= resv_addr_s;
    end
  end

  // Reservation next state: stores act first, a same-cycle LR overrides them
  always_comb begin
    resv_state_s = resv_state_r;
    resv_addr_s  = resv_addr_r;
    if (wr_enable && !w_mis_s && !w_oor_s && (wr_sc || w_match_s)) begin
      resv_state_s = IDLE;
    end else begin
      resv_state_s = resv_state_r;
    end
    if (rd_enable && rd_lr && !r_mis_s && !r_oor_s) begin
      resv_state_s = RESERVED;
      resv_addr_s  = rd_addr[31:2];
    end else begin
      resv_addr_s  = resv_addr_r;
    end
  end

  // Next response values; data fields hold when their port is idle
  always_comb begin
    fetch_valid_s     = fetch_enable;
    fetch_exc_valid_s = fetch_enable && (f_mis_s || f_oor_s);
    fetch_inst_s      = fetch_inst;
    fetch_exc_code_s  = fetch_exc_code;
    fetch_exc_value_s = fetch_exc_value;
    rd_valid_s        = rd_enable;
    rd_exc_valid_s    = rd_enable && (r_mis_s || r_oor_s);
    rd_data_s         = rd_data;
    rd_reservation_s  = rd_reservation;
    rd_exc_code_s     = rd_exc_code;
    wr_valid_s        = wr_enable;
    wr_exc_valid_s    = wr_enable && (w_mis_s || w_oor_s);
    wr_sc_fail_s      = wr_sc_fail;
    wr_exc_code_s     = wr_exc_code;

    if (fetch_enable) begin
      fetch_inst_s      = fetch_exc_valid_s ? 32'd0 : mem_r[f_off_s[IDX_W+1:2]];
      fetch_exc_code_s  = f_mis_s ? 4'd0 : (f_oor_s ? 4'd1 : 4'd0);
      fetch_exc_value_s = fetch_exc_valid_s ? fetch_addr : 32'd0;
    end else begin
      fetch_inst_s      = fetch_inst;
    end

    if (rd_enable) begin
      rd_data_s     = rd_exc_valid_s ? 32'd0 : mem_r[r_off_s[IDX_W+1:2]];
      rd_exc_code_s = r_mis_s ? 4'd4 : (r_oor_s ? 4'd5 : 4'd0);
      if (rd_exc_valid_s) begin
        rd_reservation_s = 2'b00;
      end else if (rd_lr) begin
        rd_reservation_s = {(resv_state_r == RESERVED) && !r_match_s, 1'b1};
      end else begin
        rd_reservation_s = {1'b0, r_match_s};
      end
    end else begin
      rd_data_s = rd_data;
    end

    if (wr_enable) begin
      wr_exc_code_s = w_mis_s ? 4'd6 : (w_oor_s ? 4'd7 : 4'd0);
      wr_sc_fail_s  = !wr_exc_valid_s && wr_sc && !sc_ok_s;
    end else begin
      wr_sc_fail_s  = wr_sc_fail;
    end
  end

  // Registered responses
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fetch_valid     <= 1'b0;
      fetch_inst      <= 32'd0;
      fetch_exc_valid <= 1'b0;
      fetch_exc_code  <= 4'd0;
      fetch_exc_value <= 32'd0;
      rd_valid        <= 1'b0;
      rd_data         <= 32'd0;
      rd_reservation  <= 2'd0;
      rd_exc_valid    <= 1'b0;
      rd_exc_code     <= 4'd0;
      wr_valid        <= 1'b0;
      wr_sc_fail      <= 1'b0;
      wr_exc_valid    <= 1'b0;
      wr_exc_code     <= 4'd0;
    end else begin
      fetch_valid     <= fetch_valid_s;
      fetch_inst      <= fetch_inst_s;
      fetch_exc_valid <= fetch_exc_valid_s;
      fetch_exc_code  <= fetch_exc_code_s;
      fetch_exc_value <= fetch_exc_value_s;
      rd_valid        <= rd_valid_s;
      rd_data         <= rd_data_s;
      rd_reservation  <= rd_reservation_s;
      rd_exc_valid    <= rd_exc_valid_s;
      rd_exc_code     <= rd_exc_code_s;
      wr_valid        <= wr_valid_s;
      wr_sc_fail      <= wr_sc_fail_s;
      wr_exc_valid    <= wr_exc_valid_s;
      wr_exc_code     <= wr_exc_code_s;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed table-driven bench for mem_responder (DEPTH=1024, BASE=0).
module tb_mem_responder;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        fetch_enable = 1'b0;
  logic [31:0] fetch_addr = 32'd0;
  logic        fetch_valid, fetch_exc_valid;
  logic [31:0] fetch_inst, fetch_exc_value;
  logic [3:0]  fetch_exc_code;
  logic        rd_enable = 1'b0, rd_lr = 1'b0;
  logic [31:0] rd_addr = 32'd0;
  logic        rd_valid, rd_exc_valid;
  logic [31:0] rd_data;
  logic [1:0]  rd_reservation;
  logic [3:0]  rd_exc_code;
  logic        wr_enable = 1'b0, wr_sc = 1'b0;
  logic [31:0] wr_addr = 32'd0, wr_data = 32'd0;
  logic        wr_valid, wr_sc_fail, wr_exc_valid;
  logic [3:0]  wr_exc_code;

  int tests = 0;
  int fails = 0;

  mem_responder dut (
    .CLK(CLK), .RESET(RESET),
    .fetch_enable(fetch_enable), .fetch_addr(fetch_addr),
    .fetch_valid(fetch_valid), .fetch_inst(fetch_inst),
    .fetch_exc_valid(fetch_exc_valid), .fetch_exc_code(fetch_exc_code),
    .fetch_exc_value(fetch_exc_value),
    .rd_enable(rd_enable), .rd_lr(rd_lr), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_reservation(rd_reservation),
    .rd_exc_valid(rd_exc_valid), .rd_exc_code(rd_exc_code),
    .wr_enable(wr_enable), .wr_sc(wr_sc), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_valid(wr_valid), .wr_sc_fail(wr_sc_fail),
    .wr_exc_valid(wr_exc_valid), .wr_exc_code(wr_exc_code)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    bit        fe;  bit [31:0] fa;  bit [31:0] finst; bit fexc; bit [3:0] fcode;
    bit        re;  bit lr; bit [31:0] ra; bit [31:0] rdata; bit [1:0] rres;
    bit        rexc; bit [3:0] rcode;
    bit        we;  bit sc; bit [31:0] wa; bit [31:0] wd; bit wfail;
    bit        wexc; bit [3:0] wcode;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t nv();
    vec_t v;
    v = '0;
    return v;
  endfunction

  function automatic vec_t fe(input vec_t v0, input bit [31:0] a, input bit [31:0] inst,
                              input bit exc, input bit [3:0] code);
    vec_t v = v0;
    v.fe = 1'b1; v.fa = a; v.finst = inst; v.fexc = exc; v.fcode = code;
    return v;
  endfunction

  function automatic vec_t ld(input vec_t v0, input bit [31:0] a, input bit lr,
                              input bit [31:0] d, input bit [1:0] res,
                              input bit exc, input bit [3:0] code);
    vec_t v = v0;
    v.re = 1'b1; v.lr = lr; v.ra = a; v.rdata = d; v.rres = res;
    v.rexc = exc; v.rcode = code;
    return v;
  endfunction

  function automatic vec_t st(input vec_t v0, input bit [31:0] a, input bit sc,
                              input bit [31:0] d, input bit fail,
                              input bit exc, input bit [3:0] code);
    vec_t v = v0;
    v.we = 1'b1; v.sc = sc; v.wa = a; v.wd = d; v.wfail = fail;
    v.wexc = exc; v.wcode = code;
    return v;
  endfunction

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s vec%0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  task automatic idle_inputs();
    fetch_enable = 1'b0; rd_enable = 1'b0; rd_lr = 1'b0;
    wr_enable = 1'b0; wr_sc = 1'b0;
  endtask

  // Drive one cycle of requests and check the responses one cycle later
  task automatic apply(input vec_t v, input int id);
    @(negedge CLK);
    fetch_enable = v.fe; fetch_addr = v.fa;
    rd_enable = v.re; rd_lr = v.lr; rd_addr = v.ra;
    wr_enable = v.we; wr_sc = v.sc; wr_addr = v.wa; wr_data = v.wd;
    @(posedge CLK);
    #1;
    chk("fetch_valid", id, 32'(fetch_valid), 32'(v.fe));
    chk("rd_valid", id, 32'(rd_valid), 32'(v.re));
    chk("wr_valid", id, 32'(wr_valid), 32'(v.we));
    chk("fetch_exc_valid", id, 32'(fetch_exc_valid), 32'(v.fe & v.fexc));
    chk("rd_exc_valid", id, 32'(rd_exc_valid), 32'(v.re & v.rexc));
    chk("wr_exc_valid", id, 32'(wr_exc_valid), 32'(v.we & v.wexc));
    if (v.fe) begin
      chk("fetch_inst", id, fetch_inst, v.finst);
      if (v.fexc) begin
        chk("fetch_exc_code", id, 32'(fetch_exc_code), 32'(v.fcode));
        chk("fetch_exc_value", id, fetch_exc_value, v.fa);
      end
    end
    if (v.re) begin
      chk("rd_data", id, rd_data, v.rdata);
      if (v.rexc) chk("rd_exc_code", id, 32'(rd_exc_code), 32'(v.rcode));
      else        chk("rd_reservation", id, 32'(rd_reservation), 32'(v.rres));
    end
    if (v.we) begin
      chk("wr_sc_fail", id, 32'(wr_sc_fail), 32'(v.wfail));
      if (v.wexc) chk("wr_exc_code", id, 32'(wr_exc_code), 32'(v.wcode));
    end
  endtask

  initial begin
    // Preload
    vq.push_back(st(nv(), 32'h0,  1'b0, 32'h1111_1111, 1'b0, 1'b0, 4'd0));
    vq.push_back(st(nv(), 32'h20, 1'b0, 32'h99, 1'b0, 1'b0, 4'd0));
    vq.push_back(st(nv(), 32'h24, 1'b0, 32'h42, 1'b0, 1'b0, 4'd0));
    vq.push_back(st(nv(), 32'h30, 1'b0, 32'h7,  1'b0, 1'b0, 4'd0));
    vq.push_back(st(nv(), 32'h10, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'd0));
    // Basic read back on load and fetch ports
    vq.push_back(fe(ld(nv(), 32'h10, 1'b0, 32'hDEAD_BEEF, 2'b00, 1'b0, 4'd0),
                    32'h10, 32'hDEAD_BEEF, 1'b0, 4'd0));
    // Exceptions on all three ports
    vq.push_back(fe(st(ld(nv(), 32'h13, 1'b0, 32'h0, 2'b00, 1'b1, 4'd4),
                       32'h4000, 1'b0, 32'h1234, 1'b0, 1'b1, 4'd7),
                    32'h2, 32'h0, 1'b1, 4'd0));
    vq.push_back(fe(st(ld(nv(), 32'h0, 1'b0, 32'h1111_1111, 2'b00, 1'b0, 4'd0),
                       32'h11, 1'b0, 32'h5555, 1'b0, 1'b1, 4'd6),
                    32'h4000, 32'h0, 1'b1, 4'd1));
    vq.push_back(st(ld(nv(), 32'h4000, 1'b0, 32'h0, 2'b00, 1'b1, 4'd5),
                    32'hFFFF_FFFC, 1'b0, 32'h1, 1'b0, 1'b1, 4'd7));
    // LR / SC success, then repeat SC fails
    vq.push_back(ld(nv(), 32'h20, 1'b1, 32'h99, 2'b01, 1'b0, 4'd0));
    vq.push_back(st(nv(), 32'h20, 1'b1, 32'h5, 1'b0, 1'b0, 4'd0));
    vq.push_back(st(ld(nv(), 32'h20, 1'b0, 32'h5, 2'b00, 1'b0, 4'd0),
                    32'h20, 1'b1, 32'h6, 1'b1, 1'b0, 4'd0));
    vq.push_back(ld(nv(), 32'h20, 1'b0, 32'h5, 2'b00, 1'b0, 4'd0));
    // Plain store to reserved word kills the reservation
    vq.push_back(ld(nv(), 32'h20, 1'b1, 32'h5, 2'b01, 1'b0, 4'd0));
    vq.push_back(st(nv(), 32'h20, 1'b0, 32'h8, 1'b0, 1'b0, 4'd0));
    vq.push_back(st(nv(), 32'h20, 1'b1, 32'h9, 1'b1, 1'b0, 4'd0));
    vq.push_back(ld(nv(), 32'h20, 1'b0, 32'h8, 2'b00, 1'b0, 4'd0));
    // Displaced reservation
    vq.push_back(ld(nv(), 32'h20, 1'b1, 32'h8, 2'b01, 1'b0, 4'd0));
    vq.push_back(ld(nv(), 32'h24, 1'b1, 32'h42, 2'b11, 1'b0, 4'd0));
    vq.push_back(st(nv(), 32'h20, 1'b1, 32'hA, 1'b1, 1'b0, 4'd0));
    vq.push_back(ld(nv(), 32'h24, 1'b0, 32'h42, 2'b00, 1'b0, 4'd0));
    // Read during write returns old data
    vq.push_back(st(ld(nv(), 32'h30, 1'b0, 32'h7, 2'b00, 1'b0, 4'd0),
                    32'h30, 1'b0, 32'h1, 1'b0, 1'b0, 4'd0));
    vq.push_back(ld(nv(), 32'h30, 1'b0, 32'h1, 2'b00, 1'b0, 4'd0));
    // Plain load reports held reservation; store to another word keeps it
    vq.push_back(ld(nv(), 32'h24, 1'b1, 32'h42, 2'b01, 1'b0, 4'd0));
    vq.push_back(ld(nv(), 32'h24, 1'b0, 32'h42, 2'b01, 1'b0, 4'd0));
    vq.push_back(ld(nv(), 32'h20, 1'b0, 32'h8, 2'b00, 1'b0, 4'd0));
    vq.push_back(st(nv(), 32'h20, 1'b0, 32'h3, 1'b0, 1'b0, 4'd0));
    vq.push_back(st(nv(), 32'h24, 1'b1, 32'h55, 1'b0, 1'b0, 4'd0));
    vq.push_back(ld(nv(), 32'h24, 1'b0, 32'h55, 2'b00, 1'b0, 4'd0));
    // Same-cycle LR and SC: SC sees old state, LR wins final state
    vq.push_back(ld(nv(), 32'h20, 1'b1, 32'h3, 2'b01, 1'b0, 4'd0));
    vq.push_back(st(ld(nv(), 32'h24, 1'b1, 32'h55, 2'b11, 1'b0, 4'd0),
                    32'h20, 1'b1, 32'h66, 1'b0, 1'b0, 4'd0));
    vq.push_back(st(nv(), 32'h24, 1'b1, 32'h77, 1'b0, 1'b0, 4'd0));
    vq.push_back(ld(nv(), 32'h20, 1'b0, 32'h66, 2'b00, 1'b0, 4'd0));
    vq.push_back(ld(nv(), 32'h24, 1'b0, 32'h77, 2'b00, 1'b0, 4'd0));
    // Excepting SC leaves reservation intact
    vq.push_back(ld(nv(), 32'h30, 1'b1, 32'h1, 2'b01, 1'b0, 4'd0));
    vq.push_back(st(nv(), 32'h31, 1'b1, 32'h9, 1'b0, 1'b1, 4'd6));
    vq.push_back(st(nv(), 32'h30, 1'b1, 32'h2, 1'b0, 1'b0, 4'd0));
    vq.push_back(ld(nv(), 32'h30, 1'b0, 32'h2, 2'b00, 1'b0, 4'd0));

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst fetch_valid", 0, 32'(fetch_valid), 32'd0);
    chk("rst fetch_inst", 0, fetch_inst, 32'd0);
    chk("rst fetch_exc_value", 0, fetch_exc_value, 32'd0);
    chk("rst fetch_exc_code", 0, 32'(fetch_exc_code), 32'd0);
    chk("rst rd_valid", 0, 32'(rd_valid), 32'd0);
    chk("rst rd_data", 0, rd_data, 32'd0);
    chk("rst rd_reservation", 0, 32'(rd_reservation), 32'd0);
    chk("rst wr_valid", 0, 32'(wr_valid), 32'd0);
    chk("rst wr_sc_fail", 0, 32'(wr_sc_fail), 32'd0);
    chk("rst exc_valids", 0, 32'({fetch_exc_valid, rd_exc_valid, wr_exc_valid}), 32'd0);
    @(negedge CLK);
    RESET = 1'b1;

    for (int i = 0; i < vq.size(); i++) apply(vq[i], i + 1);

    // Idle cycle: valids drop, data holds
    @(negedge CLK);
    idle_inputs();
    @(posedge CLK);
    #1;
    chk("idle rd_valid", 100, 32'(rd_valid), 32'd0);
    chk("idle wr_valid", 100, 32'(wr_valid), 32'd0);
    chk("idle rd_data hold", 100, rd_data, 32'h2);

    // Reset while a load is in flight drops it and clears the reservation
    apply(ld(nv(), 32'h20, 1'b1, 32'h66, 2'b01, 1'b0, 4'd0), 101);
    @(negedge CLK);
    idle_inputs();
    rd_enable = 1'b1; rd_addr = 32'h20;
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    chk("rst-mid rd_valid", 102, 32'(rd_valid), 32'd0);
    chk("rst-mid rd_data", 102, rd_data, 32'd0);
    @(negedge CLK);
    idle_inputs();
    RESET = 1'b1;
    apply(st(nv(), 32'h20, 1'b1, 32'hBB, 1'b1, 1'b0, 4'd0), 103);
    apply(ld(nv(), 32'h20, 1'b0, 32'h66, 2'b00, 1'b0, 4'd0), 104);

    @(negedge CLK);
    idle_inputs();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
